tone_seq_ctrl: RTL and testbench
================================

TONE_SEQ_CTRL -- requirements
Module: tone_seq_ctrl

Interface
REQ-001 Parameters SHALL be: d_w, default 16, pixel/radiance data width; addr_w, default 16, pixel memory address width; num_w, default 16, pixel count width.
REQ-002 i_clk  in  1  sole clock, all state on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 i_start  in  1  one-cycle request to process one frame; honoured only in IDLE.
REQ-005 i_total_pixels  in  num_w  pixel count N, sampled when i_start is accepted.
REQ-006 o_busy  out  1  high in every state except IDLE.
REQ-007 o_done  out  1  one-cycle pulse when frame processing ends.
REQ-008 o_mem_addr, o_mem_wdata, o_mem_wen  out  addr_w, d_w, 1  shared pixel RAM port; read data is valid the cycle after the address.
REQ-009 i_mem_rdata  in  d_w  pixel RAM read data.
REQ-010 o_eng_start  out  1  one-cycle start pulse to the tone engine.
REQ-011 o_eng_total, o_eng_rad_min, o_eng_rad_maxmin  out  num_w, d_w, d_w  engine configuration; held stable while the engine runs.
REQ-012 i_eng_addr, i_eng_wdata, i_eng_wen  in  addr_w, d_w, 1  engine memory request.
REQ-013 o_eng_rdata  out  d_w  i_mem_rdata forwarded to the engine.
REQ-014 i_eng_fin  in  1  engine finished (level, held until the next engine start).
REQ-015 i_host_addr, i_host_wdata, i_host_wen  in  addr_w, d_w, 1  host load/readback port.
REQ-016 o_host_rdata, o_host_gnt  out  d_w, 1  host read data; grant is high only in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, SCAN, DRAIN, CFG, TONE, DONE.
REQ-018 IDLE SHALL go to SCAN on i_start and latch N; if N==0 it SHALL go directly to DONE without pulsing o_eng_start.
REQ-019 SCAN SHALL issue read addresses 0..N-1 on consecutive cycles with o_mem_wen=0, then enter DRAIN for one cycle to capture the last sample.
REQ-020 Each sample returned (one cycle after its address) SHALL update run_min (initialised to all-ones) and run_max (initialised to 0) with unsigned compares; total SCAN+DRAIN time SHALL be N+1 cycles.
REQ-021 CFG (one cycle) SHALL register rad_min=run_min and rad_maxmin=run_max-run_min, using 1 instead when the difference is 0 to prevent division by zero.
REQ-022 TONE SHALL pulse o_eng_start in its first cycle, route the engine port to memory, and stay in TONE until i_eng_fin is sampled high; i_eng_fin SHALL be ignored in the start-pulse cycle.
REQ-023 DONE SHALL pulse o_done for one cycle, then return to IDLE.
REQ-024 Memory mux owner SHALL be: host in IDLE, scanner in SCAN/DRAIN, engine in TONE; otherwise o_mem_wen=0 and addr holds.
REQ-025 Non-owner write enables SHALL be ignored, with no memory side effect.
REQ-026 i_start SHALL be ignored while o_busy is high; a start coincident with DONE SHALL be ignored.
REQ-027 Configuration outputs SHALL retain their last values after DONE until the next CFG.

Reset
REQ-028 Reset SHALL force IDLE with o_busy, o_done, o_eng_start, o_mem_wen all 0.
REQ-029 Reset SHALL clear o_eng_rad_min, o_eng_rad_maxmin, o_eng_total, o_mem_addr, o_mem_wdata, run_min and run_max to 0.
REQ-030 Reset asserted mid-frame SHALL abort immediately, and no o_done SHALL follow.

Structure
REQ-031 State encoding and the default widths SHALL live in the shared tone package.
REQ-032 The min/max tracker SHALL be one sub-module, minmax_tracker, with clear, sample-valid and data inputs and min/max outputs.

Verification
REQ-033 Host load [40,10,200,90], then start with N=4 -> 5 scan cycles, rad_min=10, rad_maxmin=190, single o_eng_start pulse.
REQ-034 All pixels 77 with N=3 -> rad_min=77, rad_maxmin=1.
REQ-035 Start with N=0 -> o_done pulse 2 cycles after start, no o_eng_start, no memory access.
REQ-036 Host write during TONE -> memory unchanged and engine writes land; host write in IDLE -> written.
REQ-037 Second i_start during SCAN -> ignored, exactly one o_done.
REQ-038 Reset pulsed mid-TONE -> IDLE next edge, outputs 0, then a new start completes normally.

Source files
------------

// File: rtl/tone_seq_ctrl_pkg.sv
// Shared definitions for the tone-mapping frame sequencer: default widths
// and the controller state encoding.
package tone_seq_ctrl_pkg;

  localparam int D_W    = 16;
  localparam int ADDR_W = 16;
  localparam int NUM_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CFG   = 3'd3,
    ST_TONE  = 3'd4,
    ST_DONE  = 3'd5
  } tone_state_e;

endpackage

// File: rtl/tone_seq_ctrl_if.sv
// Shared pixel RAM port; the sequencer is the master, the RAM the slave.
// Read data returns one cycle after the address.
interface tone_seq_ctrl_if
  import tone_seq_ctrl_pkg::*;
#(
  parameter int addr_w = ADDR_W,
  parameter int d_w    = D_W
) ();

  logic [addr_w-1:0] o_mem_addr;
  logic [d_w-1:0]    o_mem_wdata;
  logic              o_mem_wen;
  logic [d_w-1:0]    i_mem_rdata;

  modport master (
    output o_mem_addr,
    output o_mem_wdata,
    output o_mem_wen,
    input  i_mem_rdata
  );

  modport slave (
    input  o_mem_addr,
    input  o_mem_wdata,
    input  o_mem_wen,
    output i_mem_rdata
  );

endinterface

// File: rtl/tone_seq_ctrl_minmax_tracker.sv
// Running unsigned min/max over a stream of pixel samples; i_clr starts a
// new frame (min to all-ones, max to zero).
module minmax_tracker
  import tone_seq_ctrl_pkg::*;
#(
  parameter int d_w = D_W
) (
  input  logic           i_clk,
  input  logic           rst_n,
  input  logic           i_clr,
  input  logic           i_vld,
  input  logic [d_w-1:0] i_data,
  output logic [d_w-1:0] o_min,
  output logic [d_w-1:0] o_max
);

  logic [d_w-1:0] r_min;
  logic [d_w-1:0] r_max;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_clr) begin
      r_min <= '1;
      r_max <= '0;
    end else if (i_vld) begin
      if (i_data < r_min) r_min <= i_data;
      if (i_data > r_max) r_max <= i_data;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/tone_seq_ctrl.sv
// Frame sequencer: scans pixel RAM for radiance min/max, configures and
// starts the tone engine, and arbitrates the single RAM port.
module tone_seq_ctrl
  import tone_seq_ctrl_pkg::*;
#(
  parameter int d_w    = D_W,
  parameter int addr_w = ADDR_W,
  parameter int num_w  = NUM_W
) (
  input  logic              i_clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [num_w-1:0]  i_total_pixels,
  output logic              o_busy,
  output logic              o_done,
  tone_seq_ctrl_if.master   mem,
  output logic              o_eng_start,
  output logic [num_w-1:0]  o_eng_total,
  output logic [d_w-1:0]    o_eng_rad_min,
  output logic [d_w-1:0]    o_eng_rad_maxmin,
  input  logic [addr_w-1:0] i_eng_addr,
  input  logic [d_w-1:0]    i_eng_wdata,
  input  logic              i_eng_wen,
  output logic [d_w-1:0]    o_eng_rdata,
  input  logic              i_eng_fin,
  input  logic [addr_w-1:0] i_host_addr,
  input  logic [d_w-1:0]    i_host_wdata,
  input  logic              i_host_wen,
  output logic [d_w-1:0]    o_host_rdata,
  output logic              o_host_gnt
);

  // The engine divides by the range, so a flat frame reports a range of 1.
  function automatic logic [d_w-1:0] safe_range(input logic [d_w-1:0] hi,
                                                input logic [d_w-1:0] lo);
    logic [d_w-1:0] diff;
    diff = hi - lo;
    return (diff == '0) ? d_w'(1) : diff;
  endfunction

  tone_state_e       r_state;
  tone_state_e       w_state_nxt;
  logic [num_w-1:0]  r_total;
  logic [num_w-1:0]  r_scan_cnt;
  logic              r_samp_vld;
  logic              r_tone_first;
  logic [addr_w-1:0] r_addr_hold;
  logic [d_w-1:0]    r_wdata_hold;
  logic [num_w-1:0]  r_eng_total;
  logic [d_w-1:0]    r_rad_min;
  logic [d_w-1:0]    r_rad_maxmin;

  logic              w_accept;
  logic              w_scan_last;
  logic [addr_w-1:0] w_mem_addr;
  logic [d_w-1:0]    w_mem_wdata;
  logic              w_mem_wen;
  logic [d_w-1:0]    w_min;
  logic [d_w-1:0]    w_max;

  assign w_accept    = (r_state == ST_IDLE) && i_start;
  assign w_scan_last = (r_scan_cnt == (r_total - num_w'(1)));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (r_total == '0)    w_state_nxt = ST_DONE;
        else if (w_scan_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: w_state_nxt = ST_CFG;
      ST_CFG:   w_state_nxt = ST_TONE;
      // Stale fin from the previous frame is still high during the start pulse.
      ST_TONE:  if (i_eng_fin && !r_tone_first) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Port owner: host in IDLE, scanner in SCAN, engine in TONE; else hold.
  always_comb begin
    w_mem_addr  = r_addr_hold;
    w_mem_wdata = r_wdata_hold;
    w_mem_wen   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_mem_addr  = i_host_addr;
        w_mem_wdata = i_host_wdata;
        w_mem_wen   = i_host_wen;
      end
      ST_SCAN: begin
        if (r_total != '0) w_mem_addr = addr_w'(r_scan_cnt);
      end
      ST_TONE: begin
        w_mem_addr  = i_eng_addr;
        w_mem_wdata = i_eng_wdata;
        w_mem_wen   = i_eng_wen;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_total      <= '0;
      r_scan_cnt   <= '0;
      r_samp_vld   <= 1'b0;
      r_tone_first <= 1'b0;
      r_addr_hold  <= '0;
      r_wdata_hold <= '0;
      r_eng_total  <= '0;
      r_rad_min    <= '0;
      r_rad_maxmin <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_samp_vld   <= (r_state == ST_SCAN) && (r_total != '0);
      r_tone_first <= (r_state == ST_CFG);
      r_addr_hold  <= w_mem_addr;
      r_wdata_hold <= w_mem_wdata;
      if (w_accept) begin
        r_total    <= i_total_pixels;
        r_scan_cnt <= '0;
      end else if (r_state == ST_SCAN) begin
        r_scan_cnt <= r_scan_cnt + num_w'(1);
      end
      if (r_state == ST_CFG) begin
        r_eng_total  <= r_total;
        r_rad_min    <= w_min;
        r_rad_maxmin <= safe_range(w_max, w_min);
      end
    end
  end

  minmax_tracker #(.d_w(d_w)) u_minmax (
    .i_clk  (i_clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_vld  (r_samp_vld),
    .i_data (mem.i_mem_rdata),
    .o_min  (w_min),
    .o_max  (w_max)
  );

  assign mem.o_mem_addr  = w_mem_addr;
  assign mem.o_mem_wdata = w_mem_wdata;
  assign mem.o_mem_wen   = w_mem_wen;

  assign o_busy           = (r_state != ST_IDLE);
  assign o_done           = (r_state == ST_DONE);
  assign o_eng_start      = (r_state == ST_TONE) && r_tone_first;
  assign o_eng_total      = r_eng_total;
  assign o_eng_rad_min    = r_rad_min;
  assign o_eng_rad_maxmin = r_rad_maxmin;
  assign o_eng_rdata      = mem.i_mem_rdata;
  assign o_host_rdata     = mem.i_mem_rdata;
  assign o_host_gnt       = (r_state == ST_IDLE);

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// Directed bench for tone_seq_ctrl with a behavioural pixel RAM and a
// scripted tone engine.
module tb_tone_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_total_pixels;
  logic        o_busy, o_done, o_eng_start;
  logic [15:0] o_eng_total, o_eng_rad_min, o_eng_rad_maxmin;
  logic [15:0] i_eng_addr, i_eng_wdata, o_eng_rdata;
  logic        i_eng_wen, i_eng_fin;
  logic [15:0] i_host_addr, i_host_wdata, o_host_rdata;
  logic        i_host_wen, o_host_gnt;

  int n_checks = 0;
  int n_errors = 0;

  int          f_starts, f_dones, f_busy_pre, f_done_cyc, f_extra;
  bit          f_addr_ok, f_busy_after;
  logic [15:0] f_rad_min, f_rad_maxmin, f_total, f_eng_rd;

  logic [15:0] ram [0:255];

  always #5 clk = ~clk;

  tone_seq_ctrl_if #(.addr_w(16), .d_w(16)) mem_if ();

  tone_seq_ctrl #(.d_w(16), .addr_w(16), .num_w(16)) dut (
    .i_clk            (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_total_pixels   (i_total_pixels),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .mem              (mem_if),
    .o_eng_start      (o_eng_start),
    .o_eng_total      (o_eng_total),
    .o_eng_rad_min    (o_eng_rad_min),
    .o_eng_rad_maxmin (o_eng_rad_maxmin),
    .i_eng_addr       (i_eng_addr),
    .i_eng_wdata      (i_eng_wdata),
    .i_eng_wen        (i_eng_wen),
    .o_eng_rdata      (o_eng_rdata),
    .i_eng_fin        (i_eng_fin),
    .i_host_addr      (i_host_addr),
    .i_host_wdata     (i_host_wdata),
    .i_host_wen       (i_host_wen),
    .o_host_rdata     (o_host_rdata),
    .o_host_gnt       (o_host_gnt)
  );

  always @(posedge clk) begin
    if (mem_if.o_mem_wen) ram[mem_if.o_mem_addr[7:0]] <= mem_if.o_mem_wdata;
    mem_if.i_mem_rdata <= ram[mem_if.o_mem_addr[7:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    i_host_addr = a; i_host_wdata = d; i_host_wen = 1'b1;
    @(negedge clk);
    i_host_wen = 1'b0;
  endtask

  task automatic host_read(input logic [15:0] a, output logic [15:0] d);
    @(negedge clk);
    i_host_addr = a; i_host_wen = 1'b0;
    @(negedge clk);
    d = o_host_rdata;
  endtask

  // Runs one frame; engine clears fin after the start pulse and raises it
  // four cycles later. Optionally a second start during SCAN and one in DONE.
  task automatic run_frame(input int n, input bit extra_starts, input bit tone_io);
    int  t_since;
    bit  started;
    logic [15:0] hold_addr;
    f_starts = 0; f_dones = 0; f_busy_pre = 0; f_done_cyc = -1; f_extra = 0;
    f_addr_ok = 1'b1; started = 1'b0; t_since = 0; f_eng_rd = 16'hxxxx;
    hold_addr = (n == 0) ? 16'h0055 : 16'(n - 1);
    @(negedge clk);
    i_host_addr = 16'h0055; i_host_wen = 1'b0;
    i_start = 1'b1; i_total_pixels = 16'(n);
    for (int cyc = 1; cyc <= 200 && f_dones == 0; cyc++) begin
      @(negedge clk);
      i_start = extra_starts && (cyc == 2);
      i_eng_wen = 1'b0; i_host_wen = 1'b0; i_host_addr = 16'h0055;
      if (o_eng_start) begin
        f_starts++;
        started = 1'b1; t_since = 0;
        f_rad_min = o_eng_rad_min; f_rad_maxmin = o_eng_rad_maxmin; f_total = o_eng_total;
      end else if (started) begin
        t_since++;
        if (t_since == 1) i_eng_fin = 1'b0;
        if (tone_io && t_since == 2) begin
          i_eng_addr = 16'd100; i_eng_wdata = 16'hBEEF; i_eng_wen = 1'b1;
          i_host_addr = 16'd101; i_host_wdata = 16'hDEAD; i_host_wen = 1'b1;
        end
        if (t_since == 3) i_eng_addr = 16'd2;
        if (t_since == 4) begin
          f_eng_rd = o_eng_rdata;
          i_eng_fin = 1'b1;
        end
      end
      if (!started && o_busy) begin
        f_busy_pre++;
        if (mem_if.o_mem_wen !== 1'b0) f_addr_ok = 1'b0;
        if (f_busy_pre <= n) begin
          if (mem_if.o_mem_addr !== 16'(f_busy_pre - 1)) f_addr_ok = 1'b0;
        end else if (mem_if.o_mem_addr !== hold_addr) begin
          f_addr_ok = 1'b0;
        end
      end
      if (o_done) begin
        f_dones++; f_done_cyc = cyc;
        i_start = extra_starts;
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    f_busy_after = o_busy;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) f_extra++;
      if (o_eng_start) f_extra++;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    bit reached;
    int late_dones;
    rst_n = 1'b0; i_start = 1'b0; i_total_pixels = '0;
    i_eng_addr = '0; i_eng_wdata = '0; i_eng_wen = 1'b0; i_eng_fin = 1'b0;
    i_host_addr = '0; i_host_wdata = '0; i_host_wen = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy",   o_busy, 0);
    check_val("rst_done",   o_done, 0);
    check_val("rst_estart", o_eng_start, 0);
    check_val("rst_wen",    mem_if.o_mem_wen, 0);
    check_val("rst_addr",   mem_if.o_mem_addr, 0);
    check_val("rst_radmin", o_eng_rad_min, 0);
    check_val("rst_radmm",  o_eng_rad_maxmin, 0);
    check_val("rst_total",  o_eng_total, 0);
    check_val("rst_gnt",    o_host_gnt, 1);
    rst_n = 1'b1;

    host_write(0, 16'd40); host_write(1, 16'd10);
    host_write(2, 16'd200); host_write(3, 16'd90);
    host_write(101, 16'h1111);
    host_read(2, rd);
    check_val("host_rd2", rd, 200);

    // Frame 1: stale fin held high going into the start pulse.
    i_eng_fin = 1'b1;
    run_frame(4, 1'b0, 1'b1);
    check_val("f1_starts",  f_starts, 1);
    check_val("f1_dones",   f_dones, 1);
    check_val("f1_donecyc", f_done_cyc, 12);
    check_val("f1_busypre", f_busy_pre, 6);
    check_val("f1_addr",    f_addr_ok, 1);
    check_val("f1_radmin",  f_rad_min, 10);
    check_val("f1_radmm",   f_rad_maxmin, 190);
    check_val("f1_total",   f_total, 4);
    check_val("f1_engrd",   f_eng_rd, 200);
    check_val("f1_idle",    f_busy_after, 0);
    check_val("f1_extra",   f_extra, 0);
    host_read(100, rd);
    check_val("eng_write",  rd, 16'hBEEF);
    host_read(101, rd);
    check_val("host_blocked", rd, 16'h1111);
    check_val("f1_retain",  o_eng_rad_maxmin, 190);

    // Frame 2: flat frame, extra start in SCAN and in DONE.
    host_write(0, 16'd77); host_write(1, 16'd77); host_write(2, 16'd77);
    run_frame(3, 1'b1, 1'b0);
    check_val("f2_starts",  f_starts, 1);
    check_val("f2_dones",   f_dones, 1);
    check_val("f2_donecyc", f_done_cyc, 11);
    check_val("f2_radmin",  f_rad_min, 77);
    check_val("f2_radmm",   f_rad_maxmin, 1);
    check_val("f2_total",   f_total, 3);
    check_val("f2_idle",    f_busy_after, 0);
    check_val("f2_extra",   f_extra, 0);

    // Frame 3: empty frame.
    run_frame(0, 1'b0, 1'b0);
    check_val("f3_starts",  f_starts, 0);
    check_val("f3_dones",   f_dones, 1);
    check_val("f3_donecyc", f_done_cyc, 2);
    check_val("f3_noaccess", f_addr_ok, 1);
    check_val("f3_busypre", f_busy_pre, 2);
    check_val("f3_retain",  o_eng_rad_min, 77);

    // Reset asserted during TONE.
    host_write(0, 16'd40); host_write(1, 16'd10);
    reached = 1'b0;
    @(negedge clk);
    i_start = 1'b1; i_total_pixels = 16'd2;
    for (int c = 0; c < 50 && !reached; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (o_eng_start) reached = 1'b1;
    end
    check_val("tone_reached", reached, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_busy",   o_busy, 0);
    check_val("mid_done",   o_done, 0);
    check_val("mid_wen",    mem_if.o_mem_wen, 0);
    check_val("mid_radmin", o_eng_rad_min, 0);
    check_val("mid_radmm",  o_eng_rad_maxmin, 0);
    check_val("mid_total",  o_eng_total, 0);
    @(negedge clk);
    rst_n = 1'b1;
    late_dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_done) late_dones++;
    end
    check_val("mid_nodone", late_dones, 0);
    run_frame(2, 1'b0, 1'b0);
    check_val("f4_starts",  f_starts, 1);
    check_val("f4_dones",   f_dones, 1);
    check_val("f4_radmin",  f_rad_min, 10);
    check_val("f4_radmm",   f_rad_maxmin, 30);
    check_val("f4_total",   f_total, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
